// File: rtl/cpu_monitor.sv
// cpu_monitor: takes a snapshot of the pipeline fetch/ALU state and counts stall
// and redirect events. It shows one 16-bit page at a time on a multiplexed 4-digit
// 7-segment display. A debounced push-button steps through the eight pages.
module cpu_monitor #(
  parameter int REFRESH_DIV     = 50000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic [31:0] Instruction_if,
  input  logic [31:0] ALUResult,
  input  logic [2:0]  JumpFlag,
  input  logic        Stall,
  input  logic        freeze,
  input  logic        clr,
  input  logic        page_btn,
  output logic [3:0]  sel,
  output logic [7:0]  data
);

  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Active-low hex font, bit order g..a
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [31:0]      pc_p0, instr_p0, alu_p0;
  logic [2:0]       jump_p0;
  logic [15:0]      stall_cnt, jump_cnt;
  logic             btn_s1, btn_s2, btn_lvl;
  logic [DEB_W-1:0] deb_cnt;
  logic             btn_rise;
  logic [2:0]       page;
  logic [REF_W-1:0] refresh_cnt;
  logic [1:0]       digit;
  logic [15:0]      field;
  logic [3:0]       nibble;
  logic             dp;
  logic [3:0]       sel_p1;
  logic [7:0]       data_p1;

  // ---- stage p0: snapshot of pipeline state, frozen while freeze is high ----
  // Capture the pipeline signals every cycle unless the user has frozen the view
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0    <= '0;
      instr_p0 <= '0;
      alu_p0   <= '0;
      jump_p0  <= '0;
    end else if (!freeze) begin
      pc_p0    <= PC;
      instr_p0 <= Instruction_if;
      alu_p0   <= ALUResult;
      jump_p0  <= JumpFlag;
    end
  end

  // Saturating stall counter; clear wins over increment and freeze is ignored
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                              stall_cnt <= '0;
    else if (clr)                            stall_cnt <= '0;
    else if (Stall && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end

  // Saturating redirect counter; any of JR/J/Z counts as one event per cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  jump_cnt <= '0;
    else if (clr)                                jump_cnt <= '0;
    else if ((|JumpFlag) && jump_cnt != 16'hFFFF) jump_cnt <= jump_cnt + 16'd1;
  end

  // Two-flop synchronizer for the raw push-button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= page_btn;
      btn_s2 <= btn_s1;
    end
  end

  // A rising debounced edge is the final accepted sample of a 0->1 change
  assign btn_rise = btn_s2 && !btn_lvl && (deb_cnt == DEB_LAST);

  // Debouncer: flip the level only after a run of identical differing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_lvl <= 1'b0;
      deb_cnt <= '0;
    end else if (btn_s2 != btn_lvl) begin
      if (deb_cnt == DEB_LAST) begin
        btn_lvl <= btn_s2;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DEB_W'(1);
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Page selector advances on each accepted press and wraps 7->0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        page <= '0;
    else if (btn_rise) page <= page + 3'd1;
  end

  // Digit scan: hold each digit for REFRESH_DIV cycles, independent of page
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit       <= '0;
    end else if (refresh_cnt == REF_LAST) begin
      refresh_cnt <= '0;
      digit       <= digit + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Select the 16-bit field for the current page, then the digit's nibble and dp
  always_comb begin
    field = '0;
    case (page)
      3'd0: field = pc_p0[15:0];
      3'd1: field = pc_p0[31:16];
      3'd2: field = instr_p0[15:0];
      3'd3: field = instr_p0[31:16];
      3'd4: field = alu_p0[15:0];
      3'd5: field = alu_p0[31:16];
      3'd6: field = stall_cnt;
      default: field = jump_cnt;
    endcase
    nibble = field[{digit, 2'b00} +: 4];
    dp     = !((digit == 2'd3 && freeze) || (digit == 2'd0 && jump_p0 != 3'b000));
  end

  // ---- stage p1: registered display drive ----
  // Register digit enables and segments so the pins are glitch-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_p1  <= 4'b1110;
      data_p1 <= 8'hC0;
    end else begin
      sel_p1  <= ~(4'b0001 << digit);
      data_p1 <= {dp, seg7(nibble)};
    end
  end

  assign sel  = sel_p1;
  assign data = data_p1;

endmodule

// File: tb/tb_cpu_monitor.sv
// Bench for cpu_monitor with a short refresh period and a short debounce period.
// Expected display frames go into a scoreboard queue when stimulus is applied.
// They are popped and compared as the DUT scans them out.
module tb_cpu_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC, Instruction_if, ALUResult;
  logic [2:0]  JumpFlag;
  logic        Stall, freeze, clr, page_btn;
  logic [3:0]  sel;
  logic [7:0]  data;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string      tag;
    logic [3:0] sel;
    logic [7:0] data;
  } frame_t;

  frame_t sb[$];

  logic [6:0] font [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  cpu_monitor #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .PC(PC), .Instruction_if(Instruction_if),
    .ALUResult(ALUResult), .JumpFlag(JumpFlag), .Stall(Stall), .freeze(freeze),
    .clr(clr), .page_btn(page_btn), .sel(sel), .data(data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clock cycles, leaving the bench 1 time unit after the edge
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pop one expected frame and compare it against the current outputs
  task automatic pop_check();
    frame_t e;
    chk("sb_underflow", 32'(sb.size() == 0), 32'd0);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "_sel"}, 32'(sel), 32'(e.sel));
      chk({e.tag, "_data"}, 32'(data), 32'(e.data));
    end
  endtask

  // Queue a full scan: four digits, each held for four cycles
  task automatic push_scan(input string tag, input logic [15:0] field,
                           input bit dp0_on, input bit dp3_on);
    frame_t f;
    logic [3:0] nib;
    bit dp_on;
    for (int d = 0; d < 4; d++) begin
      nib   = field[d*4 +: 4];
      dp_on = (d == 0 && dp0_on) || (d == 3 && dp3_on);
      for (int k = 0; k < 4; k++) begin
        f.tag  = $sformatf("%s_d%0d_c%0d", tag, d, k);
        f.sel  = ~(4'b0001 << d);
        f.data = {~dp_on, font[nib]};
        sb.push_back(f);
      end
    end
  endtask

  // Queue a scan, wait for the next digit-0 slot, then compare every cycle
  task automatic run_scan(input string tag, input logic [15:0] field,
                          input bit dp0_on, input bit dp3_on);
    logic [3:0] prev;
    bit found;
    push_scan(tag, field, dp0_on, dp3_on);
    found = 1'b0;
    @(negedge clk);
    prev = sel;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (prev != 4'b1110 && sel == 4'b1110) found = 1'b1;
      else prev = sel;
    end
    chk({tag, "_align"}, 32'(found), 32'd1);
    if (!found) begin
      sb.delete();
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (i > 0) @(negedge clk);
        pop_check();
      end
    end
    #1;
  endtask

  // Button held high for 'hi' cycles, then released long enough to settle
  task automatic press(input int hi);
    page_btn = 1'b1;
    cyc(hi);
    page_btn = 1'b0;
    cyc(6);
  endtask

  initial begin
    frame_t f;
    bit found;
    reset = 1'b0; PC = '0; Instruction_if = '0; ALUResult = '0; JumpFlag = '0;
    Stall = 1'b0; freeze = 1'b0; clr = 1'b0; page_btn = 1'b0;

    // Reset state
    cyc(3);
    f.tag = "reset_hold"; f.sel = 4'b1110; f.data = 8'hC0; sb.push_back(f);
    pop_check();

    // Release and scan PC low half
    PC = 32'h0040_1234; Instruction_if = 32'hABCD_5678; ALUResult = 32'h0000_0000;
    @(negedge clk); reset = 1'b1;
    run_scan("pc_lo", 16'h1234, 1'b0, 1'b0);

    // Freeze holds the snapshot and lights dp on digit 3
    freeze = 1'b1; cyc(2);
    PC = 32'hFFFF_FFFF;
    run_scan("frozen", 16'h1234, 1'b0, 1'b1);
    freeze = 1'b0; PC = 32'h0040_1234; cyc(2);

    // Short glitch must not change the page
    press(2);
    run_scan("glitch", 16'h1234, 1'b0, 1'b0);

    // Valid presses walk the pages
    press(5);
    run_scan("page1", 16'h0040, 1'b0, 1'b0);
    press(5);
    run_scan("page2", 16'h5678, 1'b0, 1'b0);
    press(5);
    run_scan("page3", 16'hABCD, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) press(5);
    run_scan("page_wrap8", 16'h1234, 1'b0, 1'b0);

    // Stall counter with clear on cycle 5
    for (int i = 0; i < 6; i++) press(5);
    Stall = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clr = (i == 5);
      cyc(1);
    end
    Stall = 1'b0; clr = 1'b0;
    run_scan("stall5", 16'h0005, 1'b0, 1'b0);

    // Stall counter saturation
    clr = 1'b1; cyc(1); clr = 1'b0;
    Stall = 1'b1; cyc(65534); Stall = 1'b0;
    run_scan("stall_fffe", 16'hFFFE, 1'b0, 1'b0);
    Stall = 1'b1; cyc(3); Stall = 1'b0;
    run_scan("stall_sat", 16'hFFFF, 1'b0, 1'b0);

    // Jump counter on page 7
    press(5);
    JumpFlag = 3'b100; cyc(3); JumpFlag = 3'b000;
    run_scan("jump3", 16'h0003, 1'b0, 1'b0);

    // Page wraps 7->0; snapshot JumpFlag lights digit 0 dp
    press(5);
    JumpFlag = 3'b010;
    run_scan("dp0_jump", 16'h1234, 1'b1, 1'b0);
    JumpFlag = 3'b000;

    // Async reset between edges at page 3, digit 2
    for (int i = 0; i < 3; i++) press(5);
    found = 1'b0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (sel == 4'b1011) found = 1'b1;
    end
    chk("wait_digit2", 32'(found), 32'd1);
    #2 reset = 1'b0;
    #1;
    f.tag = "async_reset"; f.sel = 4'b1110; f.data = 8'hC0; sb.push_back(f);
    pop_check();
    chk("reset_page", 32'(dut.page), 32'd0);
    chk("reset_stall_cnt", 32'(dut.stall_cnt), 32'd0);
    chk("reset_jump_cnt", 32'(dut.jump_cnt), 32'd0);
    cyc(2);
    @(negedge clk); reset = 1'b1;

    // A press in progress when reset hits gives no page advance
    cyc(1);
    page_btn = 1'b1; cyc(2);
    @(negedge clk); reset = 1'b0; page_btn = 1'b0;
    cyc(2);
    @(negedge clk); reset = 1'b1;
    cyc(8);
    run_scan("post_reset", 16'h1234, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_monitor.md
CPU_MONITOR -- requirements
Module: cpu_monitor

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000: clk cycles per display digit slot.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: consecutive stable samples required to accept a page_btn level.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 PC  input  32  fetch PC from the pipeline top.
REQ-006 Instruction_if  input  32  fetched instruction.
REQ-007 ALUResult  input  32  EX-stage ALU result.
REQ-008 JumpFlag  input  3  {JR,J,Z} redirect flags.
REQ-009 Stall  input  1  load-use stall indication.
REQ-010 freeze  input  1  level; 1 holds the snapshot.
REQ-011 clr  input  1  synchronous clear of event counters.
REQ-012 page_btn  input  1  raw asynchronous push-button; advances the display page.
REQ-013 sel  output  4  digit enables, active-low, one-hot-zero.
REQ-014 data  output  8  segments, active-low, data[7]=dp, data[6:0]=g..a.

Function
REQ-015 Snapshot: while freeze=0, PC, Instruction_if, ALUResult, JumpFlag are registered every cycle; while freeze=1, snapshot holds.
REQ-016 stall_cnt (16 bit) SHALL increment on every cycle with Stall=1, independent of freeze, saturating at 16'hFFFF.
REQ-017 jump_cnt (16 bit) SHALL increment on every cycle with |JumpFlag=1, saturating at 16'hFFFF.
REQ-018 clr=1 SHALL zero both counters on the next edge, with priority over increment.
REQ-019 page_btn SHALL pass a 2-FF synchronizer; debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples differing from current level; any mismatch restarts the count.
REQ-020 page (3 bit) SHALL increment by 1 on each accepted debounced 0->1 transition, wrapping 7->0; 1->0 transitions have no effect.
REQ-021 Page map, 16-bit field shown: 0 PC[15:0]; 1 PC[31:16]; 2 Instr[15:0]; 3 Instr[31:16]; 4 ALU[15:0]; 5 ALU[31:16]; 6 stall_cnt; 7 jump_cnt; pages 0-5 use snapshot values.
REQ-022 Refresh counter SHALL count 0..REFRESH_DIV-1; at terminal count it wraps to 0 and digit index advances 0->1->2->3->0.
REQ-023 Digit d SHALL drive sel[d]=0, other sel bits 1, and show field nibble [4d+3:4d].
REQ-024 Hex font (g..a, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-025 dp (data[7]) SHALL be 0 only on digit 3 while freeze=1; digit 0 dp SHALL be 0 when snapshot JumpFlag!=0; otherwise 1.
REQ-026 sel and data SHALL be registered: one cycle latency from digit index/field change to outputs.
REQ-027 Page change SHALL take effect on the output at the next registered update without resetting the digit scan.

Reset
REQ-028 reset=0 SHALL asynchronously force snapshot=0, counters=0, page=0, digit=0, refresh counter=0, debounced level=0, debounce counter=0, synchronizer=0.
REQ-029 During reset, sel SHALL be 4'b1110 and data 8'hC0.
REQ-030 Reset deassertion mid-scan or mid-debounce SHALL restart from reset state; no page advance results from a press in progress at reset.

Verification (REFRESH_DIV=4, DEBOUNCE_CYCLES=3)
REQ-031 Reset: hold reset=0 -> sel=1110, data=C0; release, PC=32'h0040_1234, freeze=0 -> digits 0..3 show 4,3,2,1 (data 99,B0,A4,F9), each 4 cycles.
REQ-032 Freeze: freeze=1 then PC changes to 32'hFFFF_FFFF -> display still 1234; digit 3 data=79 (dp on).
REQ-033 Debounce: page_btn glitch high 2 cycles -> page stays 0; high 5 cycles -> page=1 showing 0040; 8 valid presses from page 0 -> page back to 0.
REQ-034 Counters: 10 cycles Stall=1 with clr asserted on cycle 5 -> stall_cnt=5 on page 6; force stall_cnt=FFFE, 3 stall cycles -> FFFF held.
REQ-035 Async reset mid-operation: assert reset between edges at page 3, digit 2 -> immediately sel=1110, data=C0, page=0, counters=0.
